// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the front-panel button event generator.
//   - btn_fsm_t     : per-channel state encoding
//   - BTN_*         : bit index of each front-panel button in btn_state
//   - *_DEFAULT     : default timing constants (at a 50 MHz clk)
//   - max_int()     : helper for sizing the per-channel counter
package button_event_gen_pkg;

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        ARMED   = 2'd2,
        REPEAT  = 2'd3
    } btn_fsm_t;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    localparam int N_BTN_DEFAULT         = 5;
    localparam int HOLD_CYCLES_DEFAULT   = 50_000_000;
    localparam int REPEAT_CYCLES_DEFAULT = 10_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: turns a debounced level into press / release /
// auto-repeat single-cycle events.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   btn             : debounced level, 1 = pressed
//   press_pulse     : one cycle after the first sampled high level
//   release_pulse   : one cycle after the level drops (ARMED or REPEAT)
//   repeat_pulse    : first after HOLD_CYCLES, then every REPEAT_CYCLES
//   held            : high while the channel is in REPEAT
//   event_next      : press-or-repeat value being loaded this cycle, so the
//                     top can register any_press in step with the pulses
//   state_dbg       : current FSM state
// Handshake: none; btn is a level sampled every clk, all event outputs are
// registered single-cycle pulses with no back-pressure.
module button_event_channel
    import button_event_gen_pkg::*;
#(
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     btn,
    output logic     press_pulse,
    output logic     release_pulse,
    output logic     repeat_pulse,
    output logic     held,
    output logic     event_next,
    output btn_fsm_t state_dbg
);

    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    btn_fsm_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, repeat_d, held_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            // LOCKOUT stops a button held across reset from producing a press.
            state_q       <= LOCKOUT;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            repeat_pulse  <= repeat_d;
            held          <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            LOCKOUT: begin
                if (!btn) state_d = IDLE;
            end
            IDLE: begin
                if (btn) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ARMED: begin
                // Release is tested first so it wins over a terminal count.
                if (!btn) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == HOLD_TC) begin
                    state_d  = REPEAT;
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!btn) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_TC) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOCKOUT;
                cnt_d   = '0;
            end
        endcase

        held_d     = (state_d == REPEAT);
        event_next = press_d | repeat_d;
    end

    assign state_dbg = state_q;

endmodule

// File: rtl/button_event_gen.sv
// Front-panel button event generator: one independent event channel per
// debounced button, plus a registered any_press summary.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   btn_state     : debounced levels, 1 = pressed, synchronous to clk
//   press_pulse   : per-button one-cycle press event
//   release_pulse : per-button one-cycle release event
//   repeat_pulse  : per-button one-cycle auto-repeat event
//   held          : per-button level, high while auto-repeating
//   any_press     : OR of press and repeat events over all buttons,
//                   registered in the same cycle as those pulses
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int N_BTN         = N_BTN_DEFAULT,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
    parameter int CNT_W         = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] held,
    output logic             any_press
);

    logic [N_BTN-1:0] event_next;
    btn_fsm_t         ch_state [N_BTN];

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_event_channel #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .btn          (btn_state[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g]),
            .repeat_pulse (repeat_pulse[g]),
            .held         (held[g]),
            .event_next   (event_next[g]),
            .state_dbg    (ch_state[g])
        );
    end

    // Registered from the channels' next-cycle values so it lines up
    // exactly with the pulse registers.
    always_ff @(posedge clk) begin
        if (rst) any_press <= 1'b0;
        else     any_press <= |event_next;
    end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumes the debounced, synchronised pushbutton levels produced by the front-panel debouncer.
- Converts each level into discrete single-cycle events: press, release, and auto-repeat while held.
- Timer-setting logic and VGA menu logic consume only these events and never see raw levels.
- One independent channel per button; all channels are identical.

Parameters:
- N_BTN, 5: number of button channels.
- HOLD_CYCLES, 50_000_000: clk cycles from press to first repeat pulse; must be >= 2.
- REPEAT_CYCLES, 10_000_000: clk cycles between successive repeat pulses; must be >= 2.
- CNT_W, $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)): width of the per-channel counter.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- btn_state, in, N_BTN: debounced levels, 1 = pressed. Already synchronous to clk.
- press_pulse, out, N_BTN: one-cycle pulse on a press.
- release_pulse, out, N_BTN: one-cycle pulse on a release.
- repeat_pulse, out, N_BTN: one-cycle pulse for each auto-repeat.
- held, out, N_BTN: level, high while the channel is in REPEAT.
- any_press, out, 1: OR of press_pulse and repeat_pulse across all channels, registered alongside them.

Behaviour:
- Outputs: all registered. Reset values: press_pulse, release_pulse, repeat_pulse, held and any_press = 0. Counter = 0. Every channel state = LOCKOUT.
- Per-channel FSM states: LOCKOUT, IDLE, ARMED, REPEAT.
- LOCKOUT:
  - btn low -> IDLE.
  - btn high -> stay.
  - Emits no events. This prevents a spurious press when reset releases while a button is held.
- IDLE:
  - btn high at edge E -> ARMED, cnt <= 0, press_pulse high during the cycle after E.
  - Latency from first sampled high level to press_pulse is 1 cycle.
- ARMED:
  - btn high and cnt == HOLD_CYCLES-1 -> REPEAT, cnt <= 0, repeat_pulse. The first repeat occurs at edge E+HOLD_CYCLES.
  - btn high otherwise -> cnt <= cnt+1.
- REPEAT:
  - held = 1.
  - btn high and cnt == REPEAT_CYCLES-1 -> repeat_pulse, cnt <= 0.
  - btn high otherwise -> cnt <= cnt+1.
  - Repeat pulses are therefore spaced exactly REPEAT_CYCLES apart.
- Release: in ARMED or REPEAT, btn low -> IDLE, cnt <= 0, held <= 0, release_pulse for 1 cycle.
- Simultaneous release and terminal count: release wins. release_pulse fires, repeat_pulse does not.
- Pulse exclusivity: press_pulse, repeat_pulse and release_pulse are mutually exclusive per channel. Each lasts exactly 1 cycle.
- Fast re-press: press, release, press on consecutive cycles yields press, release, press pulses on consecutive cycles. Debouncing is upstream, so no minimum gap is enforced.
- Counter: never wraps. It is cleared on every state change, and terminal compares use == at the exact width CNT_W.
- Channel independence: channels share no state. Any combination of buttons may be active at once.
- Reset mid-operation: rst dominates on that edge. All outputs are 0 the following cycle and all channels enter LOCKOUT. A button still held after reset produces no press until it is released and pressed again.

Decomposition:
- Shared package: state encoding enum (LOCKOUT=2'd0, IDLE=2'd1, ARMED=2'd2, REPEAT=2'd3), button index constants (BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER), and default timing constants.
- Sub-module button_event_channel: one FSM, one CNT_W counter, four outputs. The top level instantiates it N_BTN times via generate and builds any_press.

Test Plan:
(All scenarios use HOLD_CYCLES=8, REPEAT_CYCLES=4, N_BTN=5.)
1. Reset with all buttons low; btn_state[0] rises before edge 10 and stays high 20 cycles -> press_pulse[0] after edge 10; repeat_pulse[0] after edges 18, 22, 26; held[0] from edge 18 until release.
2. btn_state[1] high for 3 cycles then low -> one press_pulse[1], one release_pulse[1] 3 cycles later; no repeat_pulse; held[1] stays 0.
3. btn_state[2] released on the same edge its REPEAT counter hits 3 -> release_pulse[2] only, no repeat_pulse[2], held[2] drops that cycle.
4. btn_state[3] held high through rst deassertion -> no events while held; after low for 1 cycle then high, press_pulse[3] appears normally.
5. All 5 buttons pressed on the same edge -> press_pulse = 5'b11111 and any_press = 1 for one cycle; repeats aligned 8 cycles later.
6. rst asserted during REPEAT on channel 4 -> next cycle all outputs 0 and held[4] = 0; no release_pulse is generated.
